hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, sets the register-address width.
REQ-002 Parameter MD_LATENCY, default 32, sets the multiply/divide busy duration in cycles; legal range 2..255.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rsD, rtD  input  ADDR_WIDTH  decode-stage source registers.
REQ-006 rsE, rtE  input  ADDR_WIDTH  execute-stage source registers, for the MD-start qualifier only.
REQ-007 WriteRegE, WriteRegM  input  ADDR_WIDTH  destination registers in the E and M stages.
REQ-008 RegWriteE, RegWriteM, MemtoRegE, MemtoRegM  input  1  writeback and load flags in the E and M stages.
REQ-009 BranchD  input  1  decode-stage instruction is a branch that compares registers in D.
REQ-010 MdUseD  input  1  decode-stage instruction reads HI/LO or starts a mult/div.
REQ-011 MdStartE  input  1  execute-stage instruction launches a mult/div.
REQ-012 StallF, StallD, FlushE  output  1  freeze PC and IF/ID; bubble ID/EX.
REQ-013 ForwardAD, ForwardBD  output  1  forward ALUOutM to branch comparator operands A and B.
REQ-014 MdBusy  output  1  mult/div unit occupied.
REQ-015 MdErr  output  1  one-cycle pulse on a MdStartE that is ignored.
REQ-016 StallCnt  output  16  saturating count of stall cycles.

Function
REQ-017 The block SHALL treat register 0 as never matching in every comparison.
REQ-018 The block SHALL compute lwstall = MemtoRegE & (WriteRegE==rsD | WriteRegE==rtD) combinationally.
REQ-019 The block SHALL compute brstall = BranchD & ((RegWriteE & WriteRegE matches rsD or rtD) | (MemtoRegM & WriteRegM matches rsD or rtD)).
REQ-020 The block SHALL compute mdstall = MdUseD & (state==BUSY) & !(state==BUSY & cnt==0).
REQ-021 The block SHALL drive StallF = StallD = FlushE = lwstall | brstall | mdstall with zero latency.
REQ-022 The block SHALL drive ForwardAD = (rsD matches WriteRegM) & RegWriteM, and ForwardBD likewise on rtD, combinationally.
REQ-023 The FSM SHALL have two states: IDLE and BUSY, plus an 8-bit down-counter cnt.
REQ-024 IDLE to BUSY SHALL occur on a rising edge with MdStartE=1, loading cnt = MD_LATENCY-1.
REQ-025 In BUSY, cnt SHALL decrement each cycle, and the state SHALL return to IDLE on the edge where cnt==0.
REQ-026 MdBusy SHALL equal (state==BUSY), so it is high for exactly MD_LATENCY cycles, starting the cycle after the start edge.
REQ-027 On the final BUSY cycle (cnt==0), MdUseD SHALL NOT stall; a MdStartE in that cycle SHALL reload BUSY back-to-back.
REQ-028 MdStartE in BUSY with cnt!=0 SHALL be ignored, and MdErr SHALL be registered high for the following cycle.
REQ-029 StallCnt SHALL increment on each edge where StallD=1 and SHALL hold at 16'hFFFF.
REQ-030 Simultaneous stall causes SHALL yield a single stall, and the count SHALL increment by 1 only.

Reset
REQ-031 Asserting reset SHALL immediately force state=IDLE, cnt=0, MdErr=0 and StallCnt=0.
REQ-032 During reset, MdBusy SHALL read 0, and the combinational outputs SHALL follow their inputs with mdstall=0.
REQ-033 Reset asserted mid-BUSY SHALL abandon the operation, and no MdErr SHALL result.

Structure
REQ-034 The ADDR_WIDTH default, the FSM state encoding (IDLE=0, BUSY=1) and the StallCnt width SHALL live in the shared pipeline package.
REQ-035 The multi-cycle tracker (FSM, cnt, MdErr) SHALL be one sub-module, md_busy_tracker; hazard logic and StallCnt stay in the top level.

Verification
REQ-036 Load-use: MemtoRegE=1, WriteRegE=5, rsD=5 -> StallF=StallD=FlushE=1 for that cycle only; WriteRegE=0, rsD=0 -> all 0.
REQ-037 Branch: BranchD=1, RegWriteE=1, WriteRegE=7, rtD=7 -> stall=1; then the next cycle, RegWriteM=1, WriteRegM=7, RegWriteE=0 -> stall=0, ForwardBD=1.
REQ-038 MD busy, MD_LATENCY=4: MdStartE pulse at edge 0 -> MdBusy high from edge 1 through edge 4; MdUseD held high -> stall on 3 cycles, released on the cnt==0 cycle.
REQ-039 MD error: second MdStartE two cycles after the first -> MdErr=1 for one cycle, MdBusy end time unchanged.
REQ-040 Reset mid-BUSY: assert reset asynchronously at cnt=2 -> MdBusy=0 before the next edge; StallCnt=0; a new MdStartE after release starts a full MD_LATENCY window.
REQ-041 Saturation: hold lwstall for 70000 cycles -> StallCnt=16'hFFFF and stays there.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions for the hazard unit: address width default,
// multiply/divide tracker state encoding and stall-counter width.
package hazard_unit_pkg;

  localparam int ADDR_WIDTH_DEF = 5;
  localparam int STALL_CNT_W    = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdState_t;

endpackage

// File: rtl/md_busy_tracker.sv
// Tracks occupancy of the multi-cycle multiply/divide unit with a down-counter
// and flags starts that arrive while the unit is still occupied.
//
//   state | meaning
//   IDLE  | unit free, a start launches a new operation
//   BUSY  | operation in flight, cnt counts down to its last cycle (cnt==0)
module md_busy_tracker
  import hazard_unit_pkg::*;
#(
  parameter int MD_LATENCY = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic mdStart,
  output logic mdBusy,
  output logic mdLast,
  output logic mdErr
);

  localparam logic [7:0] RELOAD = 8'(MD_LATENCY - 1);

  mdState_t   state, stateNext;
  logic [7:0] cnt, cntNext;
  logic       errNext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 8'd0;
      mdErr <= 1'b0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      mdErr <= errNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    errNext   = 1'b0;
    case (state)
      IDLE: begin
        if (mdStart) begin
          stateNext = BUSY;
          cntNext   = RELOAD;
        end
      end
      BUSY: begin
        // The last busy cycle accepts a new start so operations can chain.
        if (cnt == 8'd0) begin
          if (mdStart) cntNext = RELOAD;
          else         stateNext = IDLE;
        end else begin
          cntNext = cnt - 8'd1;
          errNext = mdStart;
        end
      end
    endcase
  end

  assign mdBusy = (state == BUSY);
  assign mdLast = mdBusy && (cnt == 8'd0);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard detection: load-use, branch-operand and mult/div stalls,
// branch-comparator forwarding, and a saturating stall-cycle counter.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int MD_LATENCY = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_WIDTH-1:0]  rsD,
  input  logic [ADDR_WIDTH-1:0]  rtD,
  input  logic [ADDR_WIDTH-1:0]  rsE,
  input  logic [ADDR_WIDTH-1:0]  rtE,
  input  logic [ADDR_WIDTH-1:0]  WriteRegE,
  input  logic [ADDR_WIDTH-1:0]  WriteRegM,
  input  logic                   RegWriteE,
  input  logic                   RegWriteM,
  input  logic                   MemtoRegE,
  input  logic                   MemtoRegM,
  input  logic                   BranchD,
  input  logic                   MdUseD,
  input  logic                   MdStartE,
  output logic                   StallF,
  output logic                   StallD,
  output logic                   FlushE,
  output logic                   ForwardAD,
  output logic                   ForwardBD,
  output logic                   MdBusy,
  output logic                   MdErr,
  output logic [STALL_CNT_W-1:0] StallCnt
);

  // Register 0 is hard-wired to zero, so it never creates a dependency.
  function automatic logic regHit(input logic [ADDR_WIDTH-1:0] a,
                                  input logic [ADDR_WIDTH-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  logic lwStall, brStall, mdStall, stall;
  logic mdLast;
  logic unusedMdOperands;

  // Execute-stage operands are reserved for a future start qualifier.
  assign unusedMdOperands = ^{rsE, rtE};

  md_busy_tracker #(
    .MD_LATENCY(MD_LATENCY)
  ) uTracker (
    .clk    (clk),
    .reset  (reset),
    .mdStart(MdStartE),
    .mdBusy (MdBusy),
    .mdLast (mdLast),
    .mdErr  (MdErr)
  );

  assign lwStall = MemtoRegE && (regHit(WriteRegE, rsD) || regHit(WriteRegE, rtD));
  assign brStall = BranchD &&
                   ((RegWriteE && (regHit(WriteRegE, rsD) || regHit(WriteRegE, rtD))) ||
                    (MemtoRegM && (regHit(WriteRegM, rsD) || regHit(WriteRegM, rtD))));
  assign mdStall = MdUseD && MdBusy && !mdLast;
  assign stall   = lwStall || brStall || mdStall;

  assign StallF    = stall;
  assign StallD    = stall;
  assign FlushE    = stall;
  assign ForwardAD = RegWriteM && regHit(WriteRegM, rsD);
  assign ForwardBD = RegWriteM && regHit(WriteRegM, rtD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCnt <= '0;
    end else if (StallD && (StallCnt != '1)) begin
      StallCnt <= StallCnt + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] rsD = '0, rtD = '0, rsE = '0, rtE = '0, WriteRegE = '0, WriteRegM = '0;
  logic       RegWriteE = 0, RegWriteM = 0, MemtoRegE = 0, MemtoRegM = 0;
  logic       BranchD = 0, MdUseD = 0, MdStartE = 0;
  logic       StallF, StallD, FlushE, ForwardAD, ForwardBD, MdBusy, MdErr;
  logic [15:0] StallCnt;

  typedef struct {
    string       name;
    logic [6:0]  vec;
    logic [15:0] cnt;
  } exp_t;

  exp_t        q[$];
  exp_t        mon;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] expCnt = 16'd0;

  hazard_unit #(.ADDR_WIDTH(5), .MD_LATENCY(4)) dut (
    .clk(clk), .reset(reset), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .RegWriteE(RegWriteE),
    .RegWriteM(RegWriteM), .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .BranchD(BranchD), .MdUseD(MdUseD), .MdStartE(MdStartE),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .ForwardAD(ForwardAD),
    .ForwardBD(ForwardBD), .MdBusy(MdBusy), .MdErr(MdErr), .StallCnt(StallCnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon = q.pop_front();
      checks += 2;
      if ({StallF, StallD, FlushE, ForwardAD, ForwardBD, MdBusy, MdErr} !== mon.vec) begin
        errors++;
        $display("FAIL %s outputs{sF,sD,fE,fA,fB,busy,err} got %b exp %b", mon.name,
                 {StallF, StallD, FlushE, ForwardAD, ForwardBD, MdBusy, MdErr}, mon.vec);
      end
      if (StallCnt !== mon.cnt) begin
        errors++;
        $display("FAIL %s StallCnt got %h exp %h", mon.name, StallCnt, mon.cnt);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setIn(input logic memE, input logic regE, input logic [4:0] wE,
                       input logic memM, input logic regM, input logic [4:0] wM,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic br, input logic use_, input logic start);
    MemtoRegE = memE; RegWriteE = regE; WriteRegE = wE;
    MemtoRegM = memM; RegWriteM = regM; WriteRegM = wM;
    rsD = rs; rtD = rt; BranchD = br; MdUseD = use_; MdStartE = start;
  endtask

  // Queue the expectation for the current cycle, then advance the count model.
  task automatic cycle(input string name, input logic st, input logic fa, input logic fb,
                       input logic busy, input logic err, input bit doCheck);
    exp_t e;
    if (doCheck) begin
      e.name = name;
      e.vec  = {st, st, st, fa, fb, busy, err};
      e.cnt  = expCnt;
      q.push_back(e);
    end
    if (st && !reset && expCnt != 16'hFFFF) expCnt++;
  endtask

  initial begin
    step();
    cycle("reset", 0, 0, 0, 0, 0, 1);
    step(); reset = 1'b0;
    cycle("postReset", 0, 0, 0, 0, 0, 1);

    // Load-use and branch hazards.
    step(); setIn(1,0,5, 0,0,0, 5,0, 0,0,0); cycle("loadUse",     1,0,0,0,0,1);
    step(); setIn(0,0,0, 0,0,0, 0,0, 0,0,0); cycle("loadUseOnce", 0,0,0,0,0,1);
    step(); setIn(1,0,0, 0,0,0, 0,0, 0,0,0); cycle("loadUseR0",   0,0,0,0,0,1);
    step(); setIn(1,0,9, 0,0,0, 3,9, 0,0,0); cycle("loadUseRt",   1,0,0,0,0,1);
    step(); setIn(0,1,7, 0,0,0, 0,7, 1,0,0); cycle("branchE",     1,0,0,0,0,1);
    step(); setIn(0,0,0, 0,1,7, 0,7, 1,0,0); cycle("branchFwdB",  0,0,1,0,0,1);
    step(); setIn(0,0,0, 1,0,4, 4,0, 1,0,0); cycle("branchLoadM", 1,0,0,0,0,1);
    step(); setIn(0,0,0, 0,1,6, 6,6, 0,0,0); cycle("fwdAB",       0,1,1,0,0,1);
    step(); setIn(0,1,0, 0,1,0, 0,0, 1,0,0); cycle("zeroReg",     0,0,0,0,0,1);
    step(); setIn(1,1,2, 0,0,0, 2,0, 1,0,0); cycle("dualCause",   1,0,0,0,0,1);
    step(); setIn(0,0,0, 0,0,0, 0,0, 0,0,0); cycle("dualCount",   0,0,0,0,0,1);

    // Mult/div busy window with MdUseD held.
    step(); setIn(0,0,0, 0,0,0, 0,0, 0,1,1); cycle("mdStart", 0,0,0,0,0,1);
    for (int i = 0; i < 3; i++) begin
      step(); MdStartE = 0; cycle("mdWait", 1,0,0,1,0,1);
    end
    step(); cycle("mdLastNoStall", 0,0,0,1,0,1);
    step(); cycle("mdDone",        0,0,0,0,0,1);

    // Back-to-back reload on the last busy cycle.
    step(); setIn(0,0,0, 0,0,0, 0,0, 0,0,1); cycle("b2bStart", 0,0,0,0,0,1);
    for (int i = 0; i < 3; i++) begin
      step(); MdStartE = 0; cycle("b2bBusy", 0,0,0,1,0,1);
    end
    step(); MdStartE = 1; cycle("b2bReload", 0,0,0,1,0,1);
    for (int i = 0; i < 4; i++) begin
      step(); MdStartE = 0; cycle("b2bSecond", 0,0,0,1,0,1);
    end
    step(); cycle("b2bDone", 0,0,0,0,0,1);

    // Ignored start while busy.
    step(); MdStartE = 1; cycle("errStart", 0,0,0,0,0,1);
    step(); MdStartE = 0; cycle("errBusy1", 0,0,0,1,0,1);
    step(); MdStartE = 1; cycle("errSecond", 0,0,0,1,0,1);
    step(); MdStartE = 0; cycle("errPulse", 0,0,0,1,1,1);
    step(); cycle("errCleared", 0,0,0,1,0,1);
    step(); cycle("errEndSame", 0,0,0,0,0,1);

    // Reset in the middle of an operation.
    step(); MdStartE = 1; cycle("rstStart", 0,0,0,0,0,1);
    step(); MdStartE = 0; cycle("rstBusy3", 0,0,0,1,0,1);
    step(); cycle("rstBusy2", 0,0,0,1,0,0);
    #2; reset = 1'b1; MdUseD = 1; MdStartE = 1; expCnt = 16'd0;
    cycle("rstAsync", 0,0,0,0,0,1);
    step(); cycle("rstHeld", 0,0,0,0,0,1);
    step(); reset = 1'b0; MdUseD = 0; cycle("rstRelease", 0,0,0,0,0,1);
    for (int i = 0; i < 4; i++) begin
      step(); MdStartE = 0; cycle("rstFullWin", 0,0,0,1,0,1);
    end
    step(); cycle("rstWinEnd", 0,0,0,0,0,1);

    // Saturation of the stall counter.
    step(); setIn(1,0,5, 0,0,0, 5,0, 0,0,0);
    cycle("sat", 1,0,0,0,0,0);
    for (int i = 1; i < 70000; i++) begin
      step();
      cycle("sat", 1,0,0,0,0, (i == 65534) || (i == 65535) || (i == 69999));
    end
    step(); setIn(0,0,0, 0,0,0, 0,0, 0,0,0); cycle("satHold", 0,0,0,0,0,1);

    repeat (3) step();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
